// File: rtl/sram_dp_param.sv
// Simple-dual-port synchronous SRAM model: one masked write port and one read port
// with a configurable read pipeline, selectable read-during-write result and clear-on-reset.
module sram_dp_param #(
  parameter int ADDRESSSIZE   = 15,
  parameter int WORDSIZE      = 16,
  parameter int BYTEWIDTH     = 8,
  parameter int READLATENCY   = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic                          iWEn,
  input  logic [ADDRESSSIZE-1:0]        iWAddr,
  input  logic [WORDSIZE-1:0]           iWData,
  input  logic [WORDSIZE/BYTEWIDTH-1:0] iWMask,
  input  logic                          iREn,
  input  logic [ADDRESSSIZE-1:0]        iRAddr,
  output logic [WORDSIZE-1:0]           oRData,
  output logic                          oRValid,
  output logic                          oInitBusy
);

  localparam int MASKSIZE = WORDSIZE / BYTEWIDTH;
  localparam int DEPTH    = 1 << ADDRESSSIZE;

  if (READLATENCY < 1 || READLATENCY > 3) begin : g_bad_latency
    $fatal(1, "sram_dp_param: READLATENCY must be 1..3");
  end
  if (WORDSIZE % BYTEWIDTH != 0) begin : g_bad_lanes
    $fatal(1, "sram_dp_param: WORDSIZE must be a multiple of BYTEWIDTH");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESSSIZE-1:0]   clr_cnt_q;
  logic [WORDSIZE-1:0]      mem [DEPTH];
  logic [WORDSIZE-1:0]      lane_en;
  logic [WORDSIZE-1:0]      wr_merged;
  logic [WORDSIZE-1:0]      rd_word;
  logic                     rd_fire;
  logic [READLATENCY-1:0]   pipe_vld;
  logic [WORDSIZE-1:0]      pipe_data [READLATENCY];

  for (genvar g = 0; g < MASKSIZE; g++) begin : g_lane
    assign lane_en[g*BYTEWIDTH +: BYTEWIDTH] = {BYTEWIDTH{iWMask[g]}};
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_cnt_q == '1) begin
      state_d = READY;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= (INIT_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  assign oInitBusy = (state_q == CLEAR);

  // The merged word serves both the write itself and the new-data bypass for a same-address read.
  always_comb begin
    wr_merged = (mem[iWAddr] & ~lane_en) | (iWData & lane_en);
    rd_word   = mem[iRAddr];
    if (RDW_MODE != 0 && iWEn && iWAddr == iRAddr) begin
      rd_word = wr_merged;
    end
  end

  assign rd_fire = (state_q == READY) && iREn;

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (iWEn) begin
        mem[iWAddr] <= wr_merged;
      end
    end
  end

  // Each stage only advances its data when the stage before it is valid, so the output holds between results.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pipe_vld <= '0;
      for (int unsigned s = 0; s < READLATENCY; s++) begin
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_fire;
      if (rd_fire) begin
        pipe_data[0] <= rd_word;
      end
      for (int unsigned s = 1; s < READLATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        if (pipe_vld[s-1]) begin
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  assign oRValid = pipe_vld[READLATENCY-1];
  assign oRData  = pipe_data[READLATENCY-1];

endmodule

// File: doc/sram_dp_param.md
Name: sram_dp_param

Overview:
- Parametrised simple-dual-port synchronous SRAM model: one write port and one read port, sharing a single clock.
- Successor to the single-port 512x16 wrapper/model pair; adds:
  - independent read/write ports
  - byte-lane write mask
  - configurable read latency with valid flag
  - defined read-during-write behaviour
  - hardware clear-on-reset sequencer
- Used as line/coefficient buffer storage in the JPEG pipeline, and as a drop-in behavioural model until a hard macro is swapped in.

Parameters:
- ADDRESSSIZE, 15: address width; depth = 2**ADDRESSSIZE words.
- WORDSIZE, 16: data width in bits.
- BYTEWIDTH, 8: write-mask lane width. WORDSIZE % BYTEWIDTH == 0 is required; MASKSIZE = WORDSIZE/BYTEWIDTH.
- READLATENCY, 1: cycles from read request to data. Legal range 1..3; other values are an elaboration error.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data, 1 = new (merged) data.
- INIT_ON_RESET, 1: 1 = zero all words after reset; 0 = contents retained across reset.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iWEn  in  1  write enable, active high.
- iWAddr  in  ADDRESSSIZE  write address.
- iWData  in  WORDSIZE  write data.
- iWMask  in  MASKSIZE  per-lane write enable; bit k covers bits [k*BYTEWIDTH +: BYTEWIDTH].
- iREn  in  1  read enable, active high.
- iRAddr  in  ADDRESSSIZE  read address.
- oRData  out  WORDSIZE  read data.
- oRValid  out  1  one-cycle pulse when oRData carries a new read result.
- oInitBusy  out  1  high while the clear sequence runs; accesses are ignored while high.

Behaviour:
- Reset (iReset=1 at an edge):
  - oRData=0, oRValid=0, all read-pipeline valid bits cleared.
  - Writes and reads in that cycle are ignored.
  - Clear FSM forced to CLEAR if INIT_ON_RESET=1, otherwise READY.
  - oInitBusy=1 in the cycle after reset when INIT_ON_RESET=1, else 0.
- Clear FSM states: CLEAR, READY.
  - CLEAR: counter starts at 0 and writes all-zero to Mem[counter] each cycle, incrementing by 1.
  - CLEAR -> READY after address 2**ADDRESSSIZE-1 is written, so CLEAR lasts exactly 2**ADDRESSSIZE cycles.
  - oInitBusy=1 throughout CLEAR, then 0 from the first READY cycle.
  - Reset asserted mid-clear restarts the counter at 0.
  - iWEn/iREn are ignored in CLEAR: no memory change, no oRValid.
- Write (READY, iWEn=1): at the edge, Mem[iWAddr] lanes with iWMask[k]=1 take iWData; other lanes keep their value. iWMask=0 is a legal no-op.
- Read (READY, iREn=1 at edge t):
  - Data sampled at edge t enters a READLATENCY-deep pipeline.
  - oRData and oRValid=1 appear after edge t+READLATENCY-1, i.e. READLATENCY cycles after the request is presented.
  - Back-to-back reads give one result per cycle with no bubbles.
  - oRData holds its last value when oRValid=0.
- Simultaneous read and write:
  - Different addresses: fully independent.
  - Same address: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged word: masked lanes from iWData, unmasked lanes from the old word.
- Address wrap: addresses are exactly ADDRESSSIZE bits; no out-of-range case exists.
- Uninitialised words (INIT_ON_RESET=0, never written): read returns X in simulation; the bench treats this as don't-care.
- Pipeline results in flight when reset asserts are discarded; oRValid is never raised for them.

Test Plan:
- Bench configuration for all scenarios unless stated: ADDRESSSIZE=4, WORDSIZE=16, BYTEWIDTH=8, READLATENCY=2, INIT_ON_RESET=1.
- Clear: pulse iReset for 1 cycle -> oInitBusy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x0000. Write 0x1234 during the clear -> later read returns 0x0000.
- Masked write: write 0xAABB mask 2'b11 to addr 5, then 0xCCDD mask 2'b01 -> read addr 5 returns 0xAADD. Mask 2'b00 write leaves 0xAADD.
- Latency/throughput: reads of addrs 0,1,2 on consecutive cycles -> oRValid high exactly 2 cycles after each request for 3 consecutive cycles, data in request order. With READLATENCY=1 and READLATENCY=3, valid arrives after 1 and 3 cycles respectively.
- Read-during-write: addr 3 holds 0x1111; same-cycle write 0x2222 mask 2'b10 and read of addr 3 -> RDW_MODE=0 returns 0x1111, RDW_MODE=1 returns 0x2211. The next read returns 0x2211 in both modes.
- Reset mid-operation: reset asserted with 2 reads in flight, and again at clear count 7 -> no oRValid for the flushed reads, oRData=0, and the clear lasts a full 16 cycles after the last reset.
- Retention: INIT_ON_RESET=0; write 0xBEEF to addr 9, pulse reset -> oInitBusy stays 0; read addr 9 returns 0xBEEF.
